// File: rtl/spm_product_deser.sv
`default_nettype none
// ============================================================================
// Module      : spm_product_deser
// Description : Collects the LSB-first serial product of the signed SPM into a
//               parallel word and offers it on a valid/ready handshake.
//               Optional zero/negative flags: define SPM_DESER_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spm_product_deser #(
  parameter int PROD_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ser_in,
  output logic              busy,
  output logic [PROD_W-1:0] prod_out,
  output logic              prod_valid,
`ifdef SPM_DESER_FLAGS_EN
  output logic              prod_zero,
  output logic              prod_neg,
`endif
  input  logic              prod_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [PROD_W-1:0]   r_shreg, w_shreg_nxt;
  logic [CNT_W-1:0]    r_cnt,   w_cnt_nxt;
  logic [PROD_W-1:0]   r_prod,  w_prod_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_busy,  w_busy_nxt;
  logic [PROD_W-1:0]   w_shift;
  logic                w_last;
`ifdef SPM_DESER_FLAGS_EN
  logic                r_zero, w_zero_nxt;
  logic                r_neg,  w_neg_nxt;
`endif

  // Stream arrives LSB first, so each new bit enters at the MSB end.
  assign w_shift = {ser_in, r_shreg[PROD_W-1:1]};
  assign w_last  = (r_cnt == CNT_W'(PROD_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
`ifdef SPM_DESER_FLAGS_EN
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_prod  <= w_prod_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
`ifdef SPM_DESER_FLAGS_EN
      r_zero  <= w_zero_nxt;
      r_neg   <= w_neg_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_prod_nxt  = r_prod;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
`ifdef SPM_DESER_FLAGS_EN
    w_zero_nxt  = r_zero;
    w_neg_nxt   = r_neg;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      SHIFT: begin
        w_shreg_nxt = w_shift;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        if (w_last) begin
          w_prod_nxt  = w_shift;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = HOLD;
`ifdef SPM_DESER_FLAGS_EN
          w_zero_nxt  = (w_shift == '0);
          w_neg_nxt   = w_shift[PROD_W-1];
`endif
        end
      end
      HOLD: begin
        // A start seen here is dropped, not queued.
        if (prod_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign busy       = r_busy;
  assign prod_out   = r_prod;
  assign prod_valid = r_valid;
`ifdef SPM_DESER_FLAGS_EN
  assign prod_zero  = r_zero;
  assign prod_neg   = r_neg;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spm_product_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_spm_product_deser
// Description : Directed self-checking bench for spm_product_deser.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spm_product_deser;

  logic        clk;
  logic        rst;
  logic        start;
  logic        ser_in;
  logic        busy;
  logic [15:0] prod_out;
  logic        prod_valid;
  logic        prod_ready;
`ifdef SPM_DESER_FLAGS_EN
  logic        prod_zero;
  logic        prod_neg;
`endif

  int n_checks = 0;
  int n_errors = 0;

  spm_product_deser #(
    .PROD_W(16),
    .CNT_W (5)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ser_in    (ser_in),
    .busy      (busy),
    .prod_out  (prod_out),
    .prod_valid(prod_valid),
`ifdef SPM_DESER_FLAGS_EN
    .prod_zero (prod_zero),
    .prod_neg  (prod_neg),
`endif
    .prod_ready(prod_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Starts a capture from IDLE and streams v; optional extra start at bit 'extra'.
  task automatic send(input string tag, input logic [15:0] v, input int extra);
    int nb;
    nb = 0;
    @(negedge clk);
    chk({tag, "_pre_valid"}, {31'd0, prod_valid}, 32'd0);
    chk({tag, "_pre_busy"},  {31'd0, busy},       32'd0);
    start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy) nb++;
      start  = (i == extra);
      ser_in = v[i];
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_cycles"}, nb, 32'd16);
    chk({tag, "_prod"},        {16'd0, prod_out}, {16'd0, v});
    chk({tag, "_valid"},       {31'd0, prod_valid}, 32'd1);
    chk({tag, "_busy_done"},   {31'd0, busy}, 32'd0);
`ifdef SPM_DESER_FLAGS_EN
    chk({tag, "_zero"}, {31'd0, prod_zero}, {31'd0, (v == 16'd0)});
    chk({tag, "_neg"},  {31'd0, prod_neg},  {31'd0, v[15]});
`endif
  endtask

  initial begin
    int held;
    rst        = 1'b1;
    start      = 1'b1;
    ser_in     = 1'b0;
    prod_ready = 1'b1;

    // Reset with start high and ser_in toggling
    repeat (2) begin
      @(negedge clk);
      ser_in = ~ser_in;
    end
    @(negedge clk);
    chk("rst_prod",  {16'd0, prod_out}, 32'd0);
    chk("rst_valid", {31'd0, prod_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_idle_busy", {31'd0, busy}, 32'd0);

    // Basic capture of -15 with ready tied high
    send("basic", 16'hFFF1, -1);
    @(negedge clk);
    chk("basic_valid_1cyc", {31'd0, prod_valid}, 32'd0);
    chk("basic_prod_kept",  {16'd0, prod_out}, 32'h0000FFF1);

    // Backpressure: ready low five cycles after valid, start pulse ignored
    prod_ready = 1'b0;
    send("bp", 16'h0F00, -1);
    held = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (prod_valid && prod_out == 16'h0F00) held++;
      start = (k == 1);
      if (k == 4) prod_ready = 1'b1;
    end
    chk("bp_hold_cycles", held, 32'd5);
    @(negedge clk);
    chk("bp_valid_drop", {31'd0, prod_valid}, 32'd0);
    chk("bp_busy",       {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("bp_stay_idle",  {31'd0, busy}, 32'd0);
    chk("bp_prod_kept",  {16'd0, prod_out}, 32'h00000F00);

    // Start during SHIFT is ignored
    send("mid_start", 16'h1234, 5);

    // Abort after 7 bits of 0xAAAA
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start  = 1'b0;
      ser_in = 1'b0;
      ser_in = (i % 2 == 1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_prod",  {16'd0, prod_out}, 32'd0);
    chk("abort_valid", {31'd0, prod_valid}, 32'd0);
    chk("abort_busy",  {31'd0, busy}, 32'd0);
    send("post_abort", 16'h8001, -1);

    // Back-to-back extremes at minimum spacing
    send("ext_4000", 16'h4000, -1);
    send("ext_0000", 16'h0000, -1);
    @(negedge clk);
    chk("ext_valid_drop", {31'd0, prod_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spm_product_deser.md
Name: spm_product_deser

Overview:
Serial-to-parallel collector on the output side of the signed 8x8 serial-parallel multiplier (SPM). It captures the SPM's serial product stream, LSB first, one bit per clk, into a PROD_W-bit two's-complement register. It presents the finished product on a valid/ready handshake to downstream logic and asserts busy while capturing, so the SPM controller knows the collector is occupied.

Parameters:
PROD_W, 16, product width in bits (2 x operand width); must be >= 2.
CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > PROD_W.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
start  input  1  one-cycle pulse; first product bit arrives on ser_in the following cycle.
ser_in  input  1  serial product bit from SPM, LSB first.
busy  output  1  high while in SHIFT state.
prod_out  output  PROD_W  assembled signed product; stable while prod_valid=1.
prod_valid  output  1  product available.
prod_ready  input  1  downstream accepts the product.

Behaviour:
- Clocking: clk drives every flop; rst is synchronous, active-high.
- Reset: state=IDLE, shreg=0, cnt=0, prod_out=0, prod_valid=0, busy=0. Reset wins over every other input in the same cycle.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - start=1 -> SHIFT, cnt<=0, busy<=1.
  - start=0 -> stay in IDLE.
  - ser_in is ignored.
- SHIFT: each cycle, shreg <= {ser_in, shreg[PROD_W-1:1]} and cnt <= cnt+1.
  - On the cycle cnt==PROD_W-1: the final shift occurs; prod_out <= {ser_in, shreg[PROD_W-1:1]}; prod_valid<=1; busy<=0; state -> HOLD.
  - start is ignored during SHIFT; no restart, no error flag.
- HOLD: prod_out and prod_valid are held.
  - prod_ready=1 -> prod_valid<=0, state -> IDLE. Handshake completes on a cycle with prod_valid&prod_ready.
  - start in HOLD is ignored. Upstream must not pulse start until prod_valid has dropped; a dropped start is not remembered.
- prod_ready may be tied high; the product is then visible for exactly one cycle.
- Latency: start sampled at edge N; bits sampled at edges N+1..N+PROD_W; prod_valid=1 after edge N+PROD_W.
  - Minimum start-to-start period: PROD_W+2 cycles.
- prod_out keeps its last value after the handshake; it changes only on completion of the next capture.
- Arithmetic: no sign extension or interpretation; bit i of the stream maps to prod_out[i]. MSB = sign bit of the two's-complement product.
- Reset mid-SHIFT or mid-HOLD aborts: partial data discarded, outputs return to reset values.

Optional Feature:
SPM_DESER_FLAGS_EN
- Defined: adds outputs prod_zero (1) and prod_neg (1).
  - Both are registered in the same edge that sets prod_valid, with prod_zero = (final value == 0) and prod_neg = final value MSB.
  - Both are held with prod_out and reset to 0.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: rst=1 for 2 cycles with start=1 and ser_in toggling -> prod_out=0, prod_valid=0, busy=0; FSM stays in IDLE.
- Basic capture: start pulse, then stream of -15 = 0xFFF1 LSB first (1,0,0,0,1,1,...,1), prod_ready=1 -> prod_out=0xFFF1, prod_valid high exactly 1 cycle, 16 cycles after start; busy high for 16 cycles.
- Backpressure: capture 0x0F00 (15*256) with prod_ready=0 for 5 cycles after valid -> prod_valid and 0x0F00 held for 6 cycles. A start pulse during the hold is ignored; the FSM returns to IDLE only when prod_ready=1.
- Extremes: back-to-back captures of 0x4000 ((-128)*(-128)) and 0x0000 at the minimum 18-cycle spacing -> both captured correctly. With SPM_DESER_FLAGS_EN: first gives prod_zero=0, prod_neg=0; second gives prod_zero=1.
- Abort: rst asserted after 7 bits of 0xAAAA -> outputs return to reset values. A fresh capture of 0x8001 then yields exactly 0x8001, with no residue from the aborted capture.
- Start during SHIFT: extra start pulse at bit 5 of 0x1234 -> capture unaffected; result 0x1234 after 16 bits.
